ram_responder: RTL

//  Responder (RAM) end of the ram* interface driven by the memory arbiter.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/ram_responder_if.sv | 24 ++
 rtl/ram_latency_ctr.sv | 35 +++
 rtl/ram_responder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word_t, ramstate_t and RAM responder defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEF   = 2;
    localparam int RAM_DEPTH_DEF = 4096;

    // Width of a counter that must hold values 0..lat inclusive.
    function automatic int ctr_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// ram* bus between the memory arbiter (master) and the RAM responder (slave).
// Latency: n/a (wires only).
// Backpressure: responder holds the master off via ramstate BUSY/ERROR.
interface ram_responder_if;
    import cpu_types_pkg::*;

    word_t     ramaddr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramaddr, ramREN, ramWEN, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramaddr, ramREN, ramWEN, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_latency_ctr.sv
// Wait-state counter: yields the effective count for the current request cycle.
// Latency: combinational eff/at_lat; count register updates on the rising edge.
// Backpressure: none; restart zeroes the count the same cycle it is raised.
module ram_latency_ctr
    import cpu_types_pkg::*;
#(
    parameter int LAT = RAM_LAT_DEF,
    localparam int CW = ctr_width(LAT)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          restart,
    input  logic          advance,
    output logic [CW-1:0] eff,
    output logic          at_lat
);

    logic [CW-1:0] cnt;

    // A new or changed request sees a zero count immediately, not a cycle later.
    assign eff    = restart ? '0 : cnt;
    assign at_lat = (eff == CW'(LAT));

    // Count up while a valid request waits; wrap to zero on ACCESS or when idle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (advance && !at_lat) begin
            cnt <= eff + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ram_responder.sv
// RAM end of the ram* bus: DEPTH-word array with LAT wait states per transfer.
// Latency: LAT BUSY cycles then one combinational ACCESS cycle; writes commit at its closing edge.
// Backpressure: ramstate BUSY/ERROR stalls the master. Option RAM_RESPONDER_STATS_EN adds rd_count/wr_count.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEF,
    parameter int DEPTH = RAM_DEPTH_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_responder_if.slave  ram
`ifdef RAM_RESPONDER_STATS_EN
    ,
    output word_t           rd_count,
    output word_t           wr_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = ctr_width(LAT);

    // Word index, op bits and (for writes) store data identify one transfer.
    typedef logic [63:0] key_t;

    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          req;
    logic          err;
    logic          valid_req;
    key_t          key;
    key_t          last_key;
    logic          last_vld;
    logic          restart;
    logic [CW-1:0] eff;
    logic          at_lat;
    logic          rd_acc;
    logic          wr_acc;
    ramstate_t     state;
    word_t         load;

    word_t mem [DEPTH];

    assign word_idx  = ram.ramaddr[31:2];
    assign mem_idx   = word_idx[AW-1:0];
    assign req       = ram.ramREN || ram.ramWEN;
    assign err       = (ram.ramREN && ram.ramWEN) || (word_idx >= 30'(DEPTH));
    assign valid_req = req && !err;
    assign key       = {word_idx, ram.ramREN, ram.ramWEN, ram.ramWEN ? ram.ramstore : 32'h0};
    assign restart   = !last_vld || (key != last_key);

    ram_latency_ctr #(
        .LAT (LAT)
    ) u_ctr (
        .CLK     (CLK),
        .nRST    (nRST),
        .restart (restart),
        .advance (valid_req),
        .eff     (eff),
        .at_lat  (at_lat)
    );

    // Decode bus state and read data; a count beyond LAT cannot occur and is flagged as ERROR.
    always_comb begin
        state  = FREE;
        load   = '0;
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (!req) begin
            state = FREE;
        end else if (err) begin
            state = ERROR;
        end else if (at_lat) begin
            state  = ACCESS;
            rd_acc = ram.ramREN;
            wr_acc = ram.ramWEN;
            if (ram.ramREN) begin
                load = mem[mem_idx];
            end
        end else if (int'(eff) < LAT) begin
            state = BUSY;
        end else begin
            state = ERROR;
        end
    end

    assign ram.ramstate = state;
    assign ram.ramload  = load;

    // Remember the last valid request so a held request keeps counting; idle/error forgets it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_key <= '0;
            last_vld <= 1'b0;
        end else if (valid_req) begin
            last_key <= key;
            last_vld <= 1'b1;
        end else begin
            last_vld <= 1'b0;
        end
    end

    // Storage is never reset; nRST gates the write so a reset on the ACCESS edge drops it.
    always_ff @(posedge CLK) begin
        if (wr_acc && nRST) begin
            mem[mem_idx] <= ram.ramstore;
        end
    end

`ifdef RAM_RESPONDER_STATS_EN
    // Saturating per-ACCESS transfer counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_acc && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
